piso_serializer: RTL and testbench

//   Parametrised parallel-in/serial-out shift register with a valid/ready load handshake.

---
 rtl/piso_serializer.sv | 148 ++++++++++++++
 tb/tb_piso_serializer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// -----------------------------------------------------------------------------
// piso_serializer
//   Parallel-in/serial-out shift register with a valid/ready load handshake.
//   A WIDTH-bit word is captured from the adder datapath and emitted one bit
//   per shift_en cycle, MSB- or LSB-first. Provides a remaining-bit count,
//   busy/done status, a synchronous flush, and gap-free back-to-back loading
//   (a new word may be accepted on the same cycle the last bit is shifted).
//
// Ports
//   clk         in   1      clock, all state updates on posedge
//   rst_n       in   1      asynchronous active-low reset
//   load_valid  in   1      load_data is valid
//   load_ready  out  1      a load is accepted this cycle if load_valid=1
//   load_data   in   WIDTH  parallel word to serialise
//   shift_en    in   1      advance one bit (ignored when idle)
//   flush       in   1      synchronous abort of the current word
//   ser_out     out  1      current serial bit (0 when idle)
//   ser_valid   out  1      ser_out carries a payload bit (same as busy)
//   busy        out  1      word in flight
//   bits_left   out  CW     bits not yet shifted out
//   done        out  1      one-cycle pulse after the last bit of a word
// -----------------------------------------------------------------------------
module piso_serializer #(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          FILL_BIT  = 1'b0,
  localparam int unsigned CW       = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  input  logic             flush,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic [CW-1:0]    bits_left,
  output logic             done
);

  // Bit position that faces the serial output.
  localparam int unsigned OUT_IDX = MSB_FIRST ? (WIDTH - 1) : 0;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    bits_left_q, bits_left_d;
  logic             done_q, done_d;

  logic             busy_s;
  logic             last_shift_s;
  logic             accept_s;

  // Move the word one place toward the output end, back-filling with FILL_BIT.
  function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
    if (MSB_FIRST) begin
      return {w[WIDTH-2:0], FILL_BIT};
    end else begin
      return {FILL_BIT, w[WIDTH-1:1]};
    end
  endfunction

  assign busy_s = (state_q == SHIFT);

  // Handshake: a new word can enter when idle or when the final bit leaves.
  always_comb begin
    last_shift_s = busy_s & shift_en & (bits_left_q == CW'(1)) & ~flush;
    load_ready   = ~flush & (~busy_s | last_shift_s);
    accept_s     = load_valid & load_ready;
  end

  // Next-state logic; flush overrides both shifting and loading.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    bits_left_d = bits_left_q;
    done_d      = 1'b0;
    if (flush) begin
      state_d     = IDLE;
      shreg_d     = '0;
      bits_left_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_s) begin
            state_d     = SHIFT;
            shreg_d     = load_data;
            bits_left_d = CW'(WIDTH);
          end else begin
            state_d = IDLE;
          end
        end
        SHIFT: begin
          if (accept_s) begin
            // Only reachable on the last shift: hand straight over to the next word.
            state_d     = SHIFT;
            shreg_d     = load_data;
            bits_left_d = CW'(WIDTH);
            done_d      = 1'b1;
          end else if (last_shift_s) begin
            state_d     = IDLE;
            shreg_d     = shift_word(shreg_q);
            bits_left_d = '0;
            done_d      = 1'b1;
          end else if (shift_en) begin
            shreg_d     = shift_word(shreg_q);
            bits_left_d = bits_left_q - CW'(1);
          end else begin
            state_d = SHIFT;
          end
        end
        default: begin
          state_d     = IDLE;
          shreg_d     = '0;
          bits_left_d = '0;
        end
      endcase
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      bits_left_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bits_left_q <= bits_left_d;
      done_q      <= done_d;
    end
  end

  assign busy      = busy_s;
  assign ser_valid = busy_s;
  assign ser_out   = busy_s & shreg_q[OUT_IDX];
  assign bits_left = bits_left_q;
  assign done      = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// -----------------------------------------------------------------------------
// tb_piso_serializer
//   Directed self-checking bench. One instance is 4-bit MSB-first, the other
//   8-bit LSB-first. Expected values are hand-derived constants.
// -----------------------------------------------------------------------------
module tb_piso_serializer;

  logic       clk;
  logic       rst_n;

  logic       lv4, lr4, se4, fl4, so4, sv4, busy4, done4;
  logic [3:0] ld4;
  logic [2:0] bl4;

  logic       lv8, lr8, se8, fl8, so8, sv8, busy8, done8;
  logic [7:0] ld8;
  logic [3:0] bl8;

  int n_assert = 0;
  int n_fail   = 0;

  logic [3:0] exp4;
  logic [7:0] exp8;

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1), .FILL_BIT(1'b0)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .load_valid(lv4), .load_ready(lr4), .load_data(ld4),
    .shift_en(se4), .flush(fl4), .ser_out(so4), .ser_valid(sv4), .busy(busy4),
    .bits_left(bl4), .done(done4)
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .FILL_BIT(1'b0)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .load_valid(lv8), .load_ready(lr8), .load_data(ld8),
    .shift_en(se8), .flush(fl8), .ser_out(so8), .ser_valid(sv8), .busy(busy8),
    .bits_left(bl8), .done(done8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    lv4 = 1'b0; ld4 = 4'h0; se4 = 1'b0; fl4 = 1'b0;
    lv8 = 1'b0; ld8 = 8'h00; se8 = 1'b0; fl8 = 1'b0;
    #2;
    chk("rst_busy4", 32'(busy4), 32'd0);
    chk("rst_ser4", 32'(so4), 32'd0);
    chk("rst_bits4", 32'(bl4), 32'd0);
    chk("rst_done4", 32'(done4), 32'd0);
    chk("rst_sv8", 32'(sv8), 32'd0);
    chk("rst_bits8", 32'(bl8), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("idle_ready4", 32'(lr4), 32'd1);

    // shift_en while idle does nothing
    se4 = 1'b1;
    tick();
    chk("idle_shift_busy4", 32'(busy4), 32'd0);
    chk("idle_shift_done4", 32'(done4), 32'd0);
    se4 = 1'b0;

    // 1: 4-bit MSB-first, continuous shifting
    lv4 = 1'b1; ld4 = 4'b1011;
    #1 chk("t1_ready", 32'(lr4), 32'd1);
    tick();
    lv4 = 1'b0; se4 = 1'b1; exp4 = 4'b1011;
    for (int i = 0; i < 4; i++) begin
      chk("t1_ser", 32'(so4), 32'(exp4[3-i]));
      chk("t1_bits", 32'(bl4), 32'(4 - i));
      chk("t1_sv", 32'(sv4), 32'd1);
      tick();
    end
    chk("t1_done", 32'(done4), 32'd1);
    chk("t1_busy_after", 32'(busy4), 32'd0);
    chk("t1_bits_after", 32'(bl4), 32'd0);
    chk("t1_ser_after", 32'(so4), 32'd0);
    se4 = 1'b0;
    tick();
    chk("t1_done_pulse", 32'(done4), 32'd0);

    // 2: 8-bit LSB-first
    lv8 = 1'b1; ld8 = 8'hA5;
    tick();
    lv8 = 1'b0; se8 = 1'b1; exp8 = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      chk("t2_ser", 32'(so8), 32'(exp8[i]));
      chk("t2_bits", 32'(bl8), 32'(8 - i));
      tick();
    end
    chk("t2_done", 32'(done8), 32'd1);
    chk("t2_busy_after", 32'(busy8), 32'd0);
    se8 = 1'b0;

    // 3: stall mid-word
    lv4 = 1'b1; ld4 = 4'b0110;
    tick();
    lv4 = 1'b0;
    chk("t3_ser0", 32'(so4), 32'd0);
    se4 = 1'b1;
    tick();
    se4 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t3_stall_ser", 32'(so4), 32'd1);
      chk("t3_stall_bits", 32'(bl4), 32'd3);
      tick();
    end
    se4 = 1'b1;
    chk("t3_ser_resume", 32'(so4), 32'd1);
    tick();
    chk("t3_ser_b1", 32'(so4), 32'd1);
    chk("t3_bits_b1", 32'(bl4), 32'd2);
    tick();
    chk("t3_ser_b0", 32'(so4), 32'd0);
    chk("t3_bits_b0", 32'(bl4), 32'd1);
    tick();
    chk("t3_done", 32'(done4), 32'd1);
    se4 = 1'b0;
    tick();

    // 4: back-to-back words, no gap
    lv4 = 1'b1; ld4 = 4'b1001;
    tick();
    lv4 = 1'b0; se4 = 1'b1; exp4 = 4'b1001;
    for (int i = 0; i < 4; i++) begin
      chk("t4_ser_a", 32'(so4), 32'(exp4[3-i]));
      chk("t4_bits_a", 32'(bl4), 32'(4 - i));
      if (i == 3) begin
        lv4 = 1'b1; ld4 = 4'b0111;
        #1 chk("t4_ready_last", 32'(lr4), 32'd1);
      end
      tick();
    end
    lv4 = 1'b0; exp4 = 4'b0111;
    chk("t4_busy_handover", 32'(busy4), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("t4_ser_b", 32'(so4), 32'(exp4[3-i]));
      chk("t4_bits_b", 32'(bl4), 32'(4 - i));
      chk("t4_done_b", 32'(done4), 32'(i == 0));
      tick();
    end
    chk("t4_done2", 32'(done4), 32'd1);
    chk("t4_busy_end", 32'(busy4), 32'd0);
    se4 = 1'b0;
    tick();

    // 5: load attempt while busy is ignored
    lv4 = 1'b1; ld4 = 4'b1100;
    tick();
    lv4 = 1'b0; se4 = 1'b1;
    chk("t5_ser0", 32'(so4), 32'd1);
    tick();
    chk("t5_ser1", 32'(so4), 32'd1);
    chk("t5_bits1", 32'(bl4), 32'd3);
    lv4 = 1'b1; ld4 = 4'b0011;
    #1 chk("t5_ready_busy", 32'(lr4), 32'd0);
    tick();
    lv4 = 1'b0;
    chk("t5_ser2", 32'(so4), 32'd0);
    chk("t5_bits2", 32'(bl4), 32'd2);
    tick();
    chk("t5_ser3", 32'(so4), 32'd0);
    chk("t5_bits3", 32'(bl4), 32'd1);
    tick();
    chk("t5_done", 32'(done4), 32'd1);
    chk("t5_busy_end", 32'(busy4), 32'd0);
    se4 = 1'b0;
    tick();

    // 6: flush with simultaneous load, then reset mid-word
    lv4 = 1'b1; ld4 = 4'b1010;
    tick();
    lv4 = 1'b0; se4 = 1'b1;
    chk("t6_ser0", 32'(so4), 32'd1);
    tick();
    chk("t6_ser1", 32'(so4), 32'd0);
    tick();
    chk("t6_ser2", 32'(so4), 32'd1);
    chk("t6_bits2", 32'(bl4), 32'd2);
    fl4 = 1'b1; lv4 = 1'b1; ld4 = 4'b1111;
    #1 chk("t6_ready_flush", 32'(lr4), 32'd0);
    tick();
    fl4 = 1'b0; lv4 = 1'b0; se4 = 1'b0;
    chk("t6_flush_busy", 32'(busy4), 32'd0);
    chk("t6_flush_bits", 32'(bl4), 32'd0);
    chk("t6_flush_ser", 32'(so4), 32'd0);
    chk("t6_flush_done", 32'(done4), 32'd0);
    tick();
    chk("t6_flush_done_later", 32'(done4), 32'd0);
    chk("t6_flush_noload", 32'(busy4), 32'd0);

    lv4 = 1'b1; ld4 = 4'b1111;
    tick();
    lv4 = 1'b0; se4 = 1'b1;
    tick();
    chk("t6_pre_rst_busy", 32'(busy4), 32'd1);
    chk("t6_pre_rst_bits", 32'(bl4), 32'd3);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", 32'(busy4), 32'd0);
    chk("t6_rst_ser", 32'(so4), 32'd0);
    chk("t6_rst_sv", 32'(sv4), 32'd0);
    chk("t6_rst_bits", 32'(bl4), 32'd0);
    chk("t6_rst_done", 32'(done4), 32'd0);
    se4 = 1'b0;
    tick();
    chk("t6_rst_done_later", 32'(done4), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("t6_after_rst_busy", 32'(busy4), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
